// File: rtl/branch_pkg.sv
// Shared types for the branch predict unit: control-transfer encoding, 2-bit
// counter states, BTB write operations and the default BTB entry layout.
package branch_pkg;

  typedef enum logic [1:0] {
    CT_NONE   = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JAL    = 2'b10,
    CT_JALR   = 2'b11
  } ctrl_transfer_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int DEF_PC_W      = 9;
  localparam int DEF_BTB_DEPTH = 16;
  localparam int DEF_IDX_W     = $clog2(DEF_BTB_DEPTH);
  localparam int DEF_TAG_W     = DEF_PC_W - DEF_IDX_W - 2;

  // Entry layout at the default geometry; btb_ram mirrors it at its own widths.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_PC_W-1:0]  target;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef enum logic [1:0] {
    WR_INVAL  = 2'b00,
    WR_BRANCH = 2'b01,
    WR_JUMP   = 2'b10
  } btb_wr_e;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// Flop-based direct-mapped BTB: one combinational read port, one synchronous
// read-modify-write port and a synchronous clear of valid bits and counters.
module btb_ram
  import branch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = DEF_BTB_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_W-1:0]  rd_target,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  btb_wr_e          wr_kind,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic             wr_taken
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  logic   wr_hit;

  // Reads see the registered table only, so a same-cycle write is not bypassed.
  assign rd_valid  = mem_q[rd_idx].valid;
  assign rd_tag    = mem_q[rd_idx].tag;
  assign rd_target = mem_q[rd_idx].target;
  assign rd_ctr    = mem_q[rd_idx].ctr;

  always_comb begin
    mem_d  = mem_q;
    wr_hit = mem_q[wr_idx].valid && (mem_q[wr_idx].tag == wr_tag);
    if (wr_en) begin
      case (wr_kind)
        WR_INVAL: mem_d[wr_idx].valid = 1'b0;
        WR_BRANCH: begin
          if (wr_hit) begin
            mem_d[wr_idx].ctr = ctr_update(mem_q[wr_idx].ctr, wr_taken);
            if (wr_taken) mem_d[wr_idx].target = wr_target;
          end else if (wr_taken) begin
            mem_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: WT};
          end
        end
        WR_JUMP: mem_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: ST};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].ctr   <= WNT;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB-based next-PC prediction at IF and branch/JAL/JALR resolution at EX with
// mispredict redirect, BTB training and saturating performance counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [PC_W-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [1:0]       ex_ctrl_transfer,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [PC_W-1:0]  rd_target;
  logic [1:0]       rd_ctr;
  logic             if_hit;

  ctrl_transfer_e   ct;
  logic             ex_live, resolve, stale, taken;
  logic [PC_W-1:0]  target, fallthrough;
  logic             wr_en;
  btb_wr_e          wr_kind;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Operand bits above the PC width and the byte offset of if_pc never matter.
  logic unused_bits;
  assign unused_bits = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W], if_pc[1:0]};

  btb_ram #(.PC_W(PC_W), .DEPTH(BTB_DEPTH)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .wr_en     (wr_en),
    .wr_kind   (wr_kind),
    .wr_idx    (ex_pc[IDX_W+1:2]),
    .wr_tag    (ex_pc[PC_W-1:IDX_W+2]),
    .wr_target (target),
    .wr_taken  (taken)
  );

  always_comb begin
    if_hit         = rd_valid && (rd_tag == if_pc[PC_W-1:IDX_W+2]);
    if_pred_taken  = if_hit && rd_ctr[1];
    if_pred_target = if_hit ? rd_target : '0;
  end

  always_comb begin
    ct          = ctrl_transfer_e'(ex_ctrl_transfer);
    ex_live     = ex_valid && !ex_stall;
    resolve     = ex_live && (ct != CT_NONE);
    stale       = ex_live && (ct == CT_NONE) && ex_pred_taken;
    fallthrough = ex_pc + PC_W'(4);
    taken       = 1'b0;
    target      = ex_pc + ex_imm[PC_W-1:0];
    case (ct)
      CT_BRANCH: taken = ex_alu_result[0];
      CT_JAL:    taken = 1'b1;
      CT_JALR: begin
        taken  = 1'b1;
        target = {ex_alu_result[PC_W-1:1], 1'b0};
      end
      default: ;
    endcase

    redirect    = 1'b0;
    redirect_pc = '0;
    if (resolve) begin
      redirect    = (ex_pred_taken != taken) || (taken && (ex_pred_target != target));
      redirect_pc = taken ? target : fallthrough;
    end else if (stale) begin
      redirect    = 1'b1;
      redirect_pc = fallthrough;
    end

    wr_en   = resolve || stale;
    wr_kind = stale ? WR_INVAL : ((ct == CT_BRANCH) ? WR_BRANCH : WR_JUMP);

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (redirect && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised scoreboard bench for branch_predict_unit against a table-level
// reference model of the BTB, redirect rules and counters.
module tb_branch_predict_unit;

  localparam int PC_W = 9;
  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PC_MASK = (1 << PC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PC_W-1:0]  if_pc;
  logic             if_pred_taken;
  logic [PC_W-1:0]  if_pred_target;
  logic             ex_valid, ex_stall;
  logic [PC_W-1:0]  ex_pc;
  logic [1:0]       ex_ctrl_transfer;
  logic [31:0]      ex_imm, ex_alu_result;
  logic             ex_pred_taken;
  logic [PC_W-1:0]  ex_pred_target;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  branch_predict_unit #(.PC_W(PC_W), .BTB_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_ctrl_transfer(ex_ctrl_transfer), .ex_imm(ex_imm),
    .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pt; int ptg; int rd; int rpc; int bc; int mc;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  bit drv_done = 0;

  // Reference state: one slot per index, plus the two counters.
  int m_valid[DEPTH], m_tag[DEPTH], m_target[DEPTH], m_ctr[DEPTH];
  int m_bc, m_mc;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_target[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic void model_lookup(input int pc, output int t, output int tg);
    int idx, tag;
    idx = (pc / 4) % DEPTH;
    tag = pc / (4 * DEPTH);
    if (m_valid[idx] != 0 && m_tag[idx] == tag) begin
      t = (m_ctr[idx] >= 2) ? 1 : 0;
      tg = m_target[idx];
    end else begin
      t = 0; tg = 0;
    end
  endfunction

  task automatic cycle(input int rn, input int ipc, input int v, input int st, input int ct,
                       input int pc, input int imm, input int alu, input int pt, input int ptg);
    exp_t e;
    int live, res, tk, tgt, ft, idx, tag, hit;
    int unsigned sum;
    @(posedge clk);
    #2;
    rst_n = rn[0]; if_pc = ipc[PC_W-1:0]; ex_valid = v[0]; ex_stall = st[0];
    ex_ctrl_transfer = ct[1:0]; ex_pc = pc[PC_W-1:0]; ex_imm = imm; ex_alu_result = alu;
    ex_pred_taken = pt[0]; ex_pred_target = ptg[PC_W-1:0];

    model_lookup(ipc, e.pt, e.ptg);
    live = (v != 0 && st == 0) ? 1 : 0;
    res = (live != 0 && ct != 0) ? 1 : 0;
    sum = int'(pc) + imm;
    tgt = int'(sum) & PC_MASK;
    tk = 0;
    if (ct == 1) tk = alu & 1;
    else if (ct == 2) tk = 1;
    else if (ct == 3) begin tk = 1; tgt = alu & (PC_MASK - 1); end
    ft = (pc + 4) & PC_MASK;
    e.rd = 0; e.rpc = 0;
    if (res != 0) begin
      e.rd = (pt != tk || (tk != 0 && ptg != tgt)) ? 1 : 0;
      e.rpc = (tk != 0) ? tgt : ft;
    end else if (live != 0 && ct == 0 && pt != 0) begin
      e.rd = 1; e.rpc = ft;
    end
    e.bc = m_bc; e.mc = m_mc;
    exp_q.push_back(e);

    if (rn == 0) begin
      model_reset();
    end else begin
      idx = (pc / 4) % DEPTH;
      tag = pc / (4 * DEPTH);
      hit = (m_valid[idx] != 0 && m_tag[idx] == tag) ? 1 : 0;
      if (res != 0 && ct == 1) begin
        if (hit != 0) begin
          m_ctr[idx] = (tk != 0) ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                 : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
          if (tk != 0) m_target[idx] = tgt;
        end else if (tk != 0) begin
          m_valid[idx] = 1; m_tag[idx] = tag; m_target[idx] = tgt; m_ctr[idx] = 2;
        end
      end else if (res != 0) begin
        m_valid[idx] = 1; m_tag[idx] = tag; m_target[idx] = tgt; m_ctr[idx] = 3;
      end else if (live != 0 && ct == 0 && pt != 0) begin
        m_valid[idx] = 0;
      end
      if (res != 0 && m_bc < CNT_MAX) m_bc++;
      if (e.rd != 0 && m_mc < CNT_MAX) m_mc++;
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("if_pred_taken", int'(if_pred_taken), e.pt);
        chk("if_pred_target", int'(if_pred_target), e.ptg);
        chk("redirect", int'(redirect), e.rd);
        chk("redirect_pc", int'(redirect_pc), e.rpc);
        chk("branch_cnt", int'(branch_cnt), e.bc);
        chk("mispred_cnt", int'(mispred_cnt), e.mc);
      end
    end
  end

  initial begin
    int pc, ipc, ct, pt, ptg, v, st, rn, imm;
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0;
    ex_ctrl_transfer = 2'b00; ex_imm = '0; ex_alu_result = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Directed walk through the main scenarios.
    cycle(0, 'h040, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h040, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h000, 1, 0, 1, 'h040, 'h20,  1,     0, 0);
    cycle(1, 'h040, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h040, 1, 0, 1, 'h040, 'h20,  0,     1, 'h060);
    cycle(1, 'h040, 1, 0, 1, 'h040, 'h20,  0,     0, 0);
    cycle(1, 'h040, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h080, 1, 0, 3, 'h080, 0,     'h0F3, 1, 'h0F2);
    cycle(1, 'h044, 1, 0, 2, 'h044, 'h100, 0,     0, 0);
    cycle(1, 'h084, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h044, 0, 0, 0, 0,      0,     0,     0, 0);
    cycle(1, 'h044, 1, 1, 1, 'h044, 'h8,   1,     0, 0);
    cycle(1, 'h044, 1, 0, 0, 'h084, 0,     0,     1, 'h010);
    cycle(1, 'h084, 1, 0, 2, 'h084, 'h1F0, 0,     0, 0);
    cycle(0, 'h044, 1, 0, 2, 'h0C4, 'h40,  0,     0, 0);
    cycle(1, 'h084, 0, 0, 0, 0,      0,     0,     0, 0);

    // Randomised traffic over a compact PC pool so entries are hit and aliased.
    for (int n = 0; n < 3000; n++) begin
      pc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, PC_MASK)) : int'($urandom_range(0, 63)) * 4;
      ipc = ($urandom_range(0, 1) == 0) ? pc : int'($urandom_range(0, 63)) * 4;
      ct  = int'($urandom_range(0, 3));
      v   = ($urandom_range(0, 9) != 0) ? 1 : 0;
      st  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rn  = ($urandom_range(0, 299) == 0) ? 0 : 1;
      imm = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 127)) * 4 - 256;
      if ($urandom_range(0, 4) < 3) model_lookup(pc, pt, ptg);
      else begin pt = int'($urandom_range(0, 1)); ptg = int'($urandom_range(0, PC_MASK)); end
      cycle(rn, ipc, v, st, ct, pc, imm, int'($urandom), pt, ptg);
    end

    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    drv_done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
